// File: rtl/sa_cmd_dispatch.sv
// sa_cmd_dispatch: command front-end for the systolic-array controller.
// Host config words are queued in a small FIFO and issued one at a time as a
// single-cycle start pulse plus a held config word. The controller's level
// done signal is tracked through ISSUE/ACK/RUN to detect completion.
// Optional feature macro: SA_CMD_DISPATCH_PERF_EN adds busy-cycle and
// retired-command performance counters with a clear input.
module sa_cmd_dispatch #(
    parameter int CFG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_cmd_valid,
    output logic                               o_cmd_ready,
    input  logic [CFG_WIDTH-1:0]               i_cmd_cfg,
    output logic                               o_sa_start,
    output logic [CFG_WIDTH-1:0]               o_sa_cfg,
    input  logic                               i_sa_done,
    output logic                               o_busy,
    output logic                               o_cmd_retired,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
`ifdef SA_CMD_DISPATCH_PERF_EN
    ,
    input  logic                               i_perf_clr,
    output logic [31:0]                        o_perf_busy_cycles,
    output logic [15:0]                        o_perf_cmd_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic [CFG_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 start_next;
    logic                 retire_next;
    logic                 busy_next;
    logic [CFG_WIDTH-1:0] cfg_next;

    // Ready depends only on the registered count, so a pop never frees a
    // slot within the same cycle; ready rises the cycle after the pop.
    assign o_cmd_ready  = (count < DEPTH_C);
    assign push         = i_cmd_valid && o_cmd_ready;
    assign o_fifo_count = count;

    // Storage write; entries need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_cmd_cfg;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state and next-output decode; an unknown state propagates X.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        start_next  = 1'b0;
        retire_next = 1'b0;
        cfg_next    = o_sa_cfg;
        case (state)
            ST_IDLE: begin
                if ((count != '0) && i_sa_done) begin
                    state_next = ST_ISSUE;
                    pop        = 1'b1;
                    start_next = 1'b1;
                    cfg_next   = mem[rd_ptr];
                end
            end
            ST_ISSUE: begin
                state_next = ST_ACK;
            end
            ST_ACK: begin
                if (!i_sa_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_sa_done) begin
                    state_next  = ST_IDLE;
                    retire_next = 1'b1;
                end
            end
            default: begin
                state_next  = 'x;
                start_next  = 1'bx;
                retire_next = 1'bx;
                cfg_next    = 'x;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // State and registered controller-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            o_sa_start    <= 1'b0;
            o_sa_cfg      <= '0;
            o_busy        <= 1'b0;
            o_cmd_retired <= 1'b0;
        end else begin
            state         <= state_next;
            o_sa_start    <= start_next;
            o_sa_cfg      <= cfg_next;
            o_busy        <= busy_next;
            o_cmd_retired <= retire_next;
        end
    end

`ifdef SA_CMD_DISPATCH_PERF_EN
    // Saturating busy-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_busy_cycles <= '0;
        end else if (i_perf_clr) begin
            o_perf_busy_cycles <= '0;
        end else if (o_busy && (o_perf_busy_cycles != '1)) begin
            o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
        end
    end

    // Saturating retired-command counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_cmd_count <= '0;
        end else if (i_perf_clr) begin
            o_perf_cmd_count <= '0;
        end else if (o_cmd_retired && (o_perf_cmd_count != '1)) begin
            o_perf_cmd_count <= o_perf_cmd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_cmd_dispatch.sv
// tb_sa_cmd_dispatch: scoreboard bench for sa_cmd_dispatch with a simple
// behavioural model of the controller's done level.
module tb_sa_cmd_dispatch;

    localparam int CFG_WIDTH  = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_cfg;
    logic             sa_start;
    logic [31:0]      sa_cfg;
    logic             sa_done;
    logic             busy;
    logic             cmd_retired;
    logic [CNT_W-1:0] fifo_count;
`ifdef SA_CMD_DISPATCH_PERF_EN
    logic             perf_clr;
    logic [31:0]      perf_busy;
    logic [15:0]      perf_cmd;
`endif

    logic [31:0] exp_q [$];
    logic [31:0] cur_cfg = '0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_count = 0;
    int retire_count = 0;
    int busy_seen = 0;
    int peak = 0;
    int rise_cyc = 0;
    bit rise_valid = 0;
    bit gap_mode = 0;
    bit hold_low = 0;
    bit pre = 0;
    int run_len = 20;
    int run_left = 0;

    always #5 clk = ~clk;

    sa_cmd_dispatch #(.CFG_WIDTH(CFG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_cfg(cmd_cfg),
        .o_sa_start(sa_start),
        .o_sa_cfg(sa_cfg),
        .i_sa_done(sa_done),
        .o_busy(busy),
        .o_cmd_retired(cmd_retired),
        .o_fifo_count(fifo_count)
`ifdef SA_CMD_DISPATCH_PERF_EN
        ,
        .i_perf_clr(perf_clr),
        .o_perf_busy_cycles(perf_busy),
        .o_perf_cmd_count(perf_cmd)
`endif
    );

    // Free-running cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Controller model: done stays 1 for the preload cycle, then low for run_len cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            sa_done  = 1'b0;
            pre      = 1'b0;
            run_left = 0;
        end else if (hold_low) begin
            sa_done = 1'b0;
        end else if (sa_start) begin
            pre     = 1'b1;
            sa_done = 1'b1;
        end else if (pre) begin
            pre      = 1'b0;
            run_left = run_len;
            sa_done  = 1'b0;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                sa_done    = 1'b1;
                rise_cyc   = cyc;
                rise_valid = 1'b1;
            end
        end else begin
            sa_done = 1'b1;
        end
    end

    // Monitor: pops the expected config on every start and checks stability while busy.
    always @(negedge clk) begin
        logic [31:0] exp_cfg;
        if (rst_n) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (sa_start) begin
                start_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_start", 32'(sa_start), 32'd0);
                end else begin
                    exp_cfg = exp_q.pop_front();
                    checkOutput("start_cfg", sa_cfg, exp_cfg);
                    cur_cfg = exp_cfg;
                end
                if (gap_mode && rise_valid) checkOutput("b2b_gap", 32'(cyc - rise_cyc), 32'd2);
                rise_valid = 1'b0;
            end else if (busy) begin
                checkOutput("cfg_stable", sa_cfg, cur_cfg);
            end
            if (cmd_retired) retire_count++;
            if (busy) busy_seen++;
        end
    end

    task automatic applyStimulus(input logic [31:0] cfg);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_cfg   = cfg;
        while (!cmd_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("push_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back(cfg);
            tick(1);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic waitStart(input int limit);
        int n = 0;
        while (!sa_start && n < limit) begin
            tick(1);
            n++;
        end
        if (!sa_start) checkOutput("start_timeout", 32'(sa_start), 32'd1);
    endtask

    task automatic waitRetires(input int target, input int limit);
        int n = 0;
        while (retire_count < target && n < limit) begin
            tick(1);
            n++;
        end
        checkOutput("retire_count", 32'(retire_count), 32'(target));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start"}, 32'(sa_start), 32'd0);
        checkOutput({tag, "_cfg"}, sa_cfg, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_retired"}, 32'(cmd_retired), 32'd0);
        checkOutput({tag, "_count"}, 32'(fifo_count), 32'd0);
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int base_s;
        int base_r;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_cfg   = '0;
`ifdef SA_CMD_DISPATCH_PERF_EN
        perf_clr  = 1'b0;
`endif
        tick(1);
        checkResetValues("reset");
        rst_n = 1'b1;
        tick(1);

        // Single command with a 20-cycle run.
        applyStimulus(32'hA5A5_0001);
        waitStart(20);
        checkOutput("single_cfg", sa_cfg, 32'hA5A5_0001);
        checkOutput("single_busy", 32'(busy), 32'd1);
        tick(1);
        checkOutput("start_width", 32'(sa_start), 32'd0);
        waitRetires(1, 100);
        checkOutput("retire_pulse", 32'(cmd_retired), 32'd1);
        checkOutput("busy_fall", 32'(busy), 32'd0);
        checkOutput("count_empty", 32'(fifo_count), 32'd0);
        tick(1);
        checkOutput("retire_width", 32'(cmd_retired), 32'd0);
        checkOutput("retire_once", 32'(retire_count), 32'd1);

        // Three back-to-back commands queued while done is held low.
        hold_low = 1'b1;
        peak = 0;
        tick(2);
        applyStimulus(32'h0000_0C01);
        applyStimulus(32'h0000_0C02);
        applyStimulus(32'h0000_0C03);
        checkOutput("b2b_count", 32'(fifo_count), 32'd3);
        base_s = start_count;
        base_r = retire_count;
        rise_valid = 1'b0;
        gap_mode = 1'b1;
        run_len = 8;
        hold_low = 1'b0;
        waitRetires(base_r + 3, 200);
        gap_mode = 1'b0;
        checkOutput("b2b_peak", 32'(peak), 32'd3);
        checkOutput("b2b_starts", 32'(start_count - base_s), 32'd3);

        // Backpressure: fill the FIFO, then a fifth command waits for the first pop.
        hold_low = 1'b1;
        run_len = 6;
        tick(2);
        base_s = start_count;
        base_r = retire_count;
        applyStimulus(32'h0000_0D00);
        applyStimulus(32'h0000_0D01);
        applyStimulus(32'h0000_0D02);
        applyStimulus(32'h0000_0D03);
        checkOutput("full_count", 32'(fifo_count), 32'd4);
        checkOutput("full_ready", 32'(cmd_ready), 32'd0);
        fork
            applyStimulus(32'h0000_0D04);
            begin
                tick(3);
                checkOutput("still_full", 32'(fifo_count), 32'd4);
                hold_low = 1'b0;
                waitStart(20);
                checkOutput("count_at_pop", 32'(fifo_count), 32'd3);
                checkOutput("ready_after_pop", 32'(cmd_ready), 32'd1);
                tick(1);
                checkOutput("fifth_accepted", 32'(fifo_count), 32'd4);
            end
        join
        waitRetires(base_r + 5, 300);
        checkOutput("bp_starts", 32'(start_count - base_s), 32'd5);
        checkOutput("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // Done held low after reset: no start until done rises.
        rst_n = 1'b0;
        hold_low = 1'b1;
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        base_s = start_count;
        base_r = retire_count;
        applyStimulus(32'h0000_0E00);
        tick(10);
        checkOutput("no_start_done_low", 32'(start_count - base_s), 32'd0);
        checkOutput("held_count", 32'(fifo_count), 32'd1);
        hold_low = 1'b0;
        tick(2);
        checkOutput("start_after_done", 32'(sa_start), 32'd1);
        waitRetires(base_r + 1, 100);

        // Reset asserted mid-run with two commands queued.
        run_len = 30;
        applyStimulus(32'h0000_0F00);
        applyStimulus(32'h0000_0F01);
        applyStimulus(32'h0000_0F02);
        tick(5);
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_queued", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        exp_q.delete();
        base_s = start_count;
        #2;
        rst_n = 1'b1;
        tick(10);
        checkOutput("post_reset_nostart", 32'(start_count - base_s), 32'd0);
        checkOutput("post_reset_count", 32'(fifo_count), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

`ifdef SA_CMD_DISPATCH_PERF_EN
        // Performance counters: two 15-cycle runs, then clear against increments.
        run_len = 15;
        perf_clr = 1'b1;
        tick(1);
        perf_clr = 1'b0;
        busy_seen = 0;
        checkOutput("perf_cleared", perf_busy, 32'd0);
        base_r = retire_count;
        applyStimulus(32'h0000_1000);
        applyStimulus(32'h0000_1001);
        waitRetires(base_r + 2, 200);
        tick(2);
        checkOutput("perf_cmd_count", 32'(perf_cmd), 32'd2);
        checkOutput("perf_busy_const", perf_busy, 32'd34);
        checkOutput("perf_busy_seen", perf_busy, 32'(busy_seen));
        base_r = retire_count;
        applyStimulus(32'h0000_1002);
        waitStart(20);
        tick(3);
        perf_clr = 1'b1;
        tick(1);
        perf_clr = 1'b0;
        checkOutput("clr_vs_busy_inc", perf_busy, 32'd0);
        waitRetires(base_r + 1, 100);
        perf_clr = 1'b1;
        tick(1);
        perf_clr = 1'b0;
        checkOutput("clr_vs_cmd_inc", 32'(perf_cmd), 32'd0);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
